tray_reader: RTL
================

Name: tray_reader

Overview:
- Unloads the ball tray after a run and streams the collected ball colours, oldest first, over a valid/ready interface.
- Per unload, produces blue/red tallies and the tray read as a binary word (red = 1).
- Sits on the board's tray side and consumes its tray[5:0], tray_amount[2:0] and no_balls outputs.
- Fully synchronous. The board-side inputs are sampled once per unload.

Parameters:
- TRAY_DEPTH, 6: number of tray slots, i.e. the width of tray_in.
- IDX_W, 3: width of tray_amount and the internal index.
- AUTO_UNLOAD, 0: when 1, a rising edge on no_balls starts an unload, same as an unload pulse.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- tray_in  in  TRAY_DEPTH  tray contents; bit i = colour of ball i (0 = BLUE, 1 = RED).
- tray_amount  in  IDX_W  number of balls in the tray.
- no_balls  in  1  board's out-of-balls flag; used only when AUTO_UNLOAD = 1.
- unload  in  1  one-cycle start request.
- busy  out  1  high from LOAD through DONE.
- ball_valid  out  1  a ball colour is presented.
- ball_color  out  1  colour of the presented ball.
- ball_last  out  1  presented ball is the final one.
- ball_ready  in  1  sink accepts the ball.
- blue_count  out  IDX_W  blues accepted in this unload.
- red_count  out  IDX_W  reds accepted in this unload.
- tray_value  out  TRAY_DEPTH  bit i = colour of accepted ball i; all other bits 0.
- done  out  1  one-cycle pulse at the end of an unload.
- overflow  out  1  tray_amount exceeded TRAY_DEPTH; sticky until the next LOAD.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs return to 0, including ball_valid, done, counts, tray_value and overflow.
  - no_balls edge-detect register is cleared to 0.
  - Reset mid-stream abandons the stream; ball_valid is low on the next cycle.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - A start is unload = 1, or (AUTO_UNLOAD and no_balls = 1 while previous sampled no_balls = 0).
  - On a start, go to LOAD.
  - Start requests arriving in any other state are ignored, not queued.
- LOAD (one cycle):
  - Snapshot tray_in and n = min(tray_amount, TRAY_DEPTH).
  - overflow <= (tray_amount > TRAY_DEPTH).
  - Clear blue_count, red_count and tray_value; idx <= 0.
  - Next state is DONE if n = 0, otherwise SEND.
  - busy = 1.
- SEND:
  - ball_valid = 1, ball_color = snap[idx], ball_last = (idx == n-1).
  - On ball_valid & ball_ready:
    - tray_value[idx] <= snap[idx].
    - Increment red_count if the colour is red, otherwise blue_count.
    - idx increments.
    - If ball_last, go to DONE.
  - Without ready, ball_color and ball_last hold steady and ball_valid stays high (no retraction).
  - Back-to-back accepts give one ball per cycle.
- DONE (one cycle):
  - done = 1, busy = 1, ball_valid = 0.
  - Then go to IDLE.
  - Counts, tray_value and overflow hold until the next LOAD.
- Tray changes after LOAD do not affect the stream in progress.
- Invariant at done: blue_count + red_count = n.
- Latency: the unload pulse at cycle t gives first ball_valid at t+2. With ready held high, done occurs at t+2+n.
- Width: counts never exceed TRAY_DEPTH, so no wrap is possible.
- The no_balls edge detector samples every cycle, including when not in IDLE. An edge that occurs while busy is lost.

Test Plan:
- Normal unload:
  - Stimulus: tray_in = 6'b101001, tray_amount = 6, unload pulse, ball_ready = 1.
  - Response: colours 1,0,0,1,0,1 on consecutive cycles with last on the 6th; done; blue_count = 3, red_count = 3, tray_value = 6'b101001.
- Empty tray:
  - Stimulus: tray_amount = 0, unload.
  - Response: no ball_valid; done 2 cycles after unload; counts 0; tray_value = 0.
- Overflow:
  - Stimulus: tray_amount = 7, tray_in = 6'b111111, unload.
  - Response: exactly 6 balls; overflow = 1; red_count = 6.
- Back-pressure:
  - Stimulus: tray_amount = 3, tray_in = 6'b000010, ball_ready toggling 0/1 every cycle.
  - Response: each ball held stable until accepted; sequence 0,1,0; tray_value = 6'b000010.
- Auto and ignore:
  - Stimulus: AUTO_UNLOAD = 1, no_balls rises, then unload pulses during SEND.
  - Response: one unload only; busy drops one cycle after done.
- Reset mid-stream:
  - Stimulus: rst_n = 0 after 2 of 5 balls accepted.
  - Response: next cycle ball_valid = 0, counts = 0, tray_value = 0, FSM in IDLE; a fresh unload restarts from ball 0.

Source files
------------

// File: rtl/tray_reader_if.sv
// Ball stream handshake between tray_reader (master) and a colour sink (slave).
interface tray_reader_if;
    logic ball_valid;
    logic ball_color;
    logic ball_last;
    logic ball_ready;

    modport master (
        output ball_valid,
        output ball_color,
        output ball_last,
        input  ball_ready
    );

    modport slave (
        input  ball_valid,
        input  ball_color,
        input  ball_last,
        output ball_ready
    );
endinterface

// File: rtl/tray_reader.sv
// Unloads a snapshot of the ball tray, streams colours oldest first and tallies them.
module tray_reader #(
    parameter int unsigned TRAY_DEPTH  = 6,
    parameter int unsigned IDX_W       = 3,
    parameter bit          AUTO_UNLOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TRAY_DEPTH-1:0] tray_in,
    input  logic [IDX_W-1:0]      tray_amount,
    input  logic                  no_balls,
    input  logic                  unload,
    tray_reader_if.master         ball,
    output logic                  busy,
    output logic [IDX_W-1:0]      blue_count,
    output logic [IDX_W-1:0]      red_count,
    output logic [TRAY_DEPTH-1:0] tray_value,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    localparam logic [IDX_W-1:0] DepthW = IDX_W'(TRAY_DEPTH);
    localparam logic [IDX_W-1:0] OneW   = IDX_W'(1);

    state_e                state_q, state_d;
    logic [TRAY_DEPTH-1:0] snap_q;
    logic [TRAY_DEPTH-1:0] tray_q;
    logic [IDX_W-1:0]      n_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      blue_q;
    logic [IDX_W-1:0]      red_q;
    logic                  ovf_q;
    logic                  nb_prev_q;

    logic                  start;
    logic                  amount_ovf;
    logic [IDX_W-1:0]      n_clamped;
    logic                  cur_color;
    logic                  cur_last;

    assign amount_ovf = (tray_amount > DepthW);
    assign n_clamped  = amount_ovf ? DepthW : tray_amount;
    assign start      = unload | (AUTO_UNLOAD & no_balls & ~nb_prev_q);
    assign cur_color  = snap_q[idx_q];
    assign cur_last   = (idx_q == (n_q - OneW));

    always_comb begin
        state_d         = state_q;
        ball.ball_valid = 1'b0;
        ball.ball_color = 1'b0;
        ball.ball_last  = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                busy    = 1'b1;
                state_d = (n_clamped == '0) ? StDone : StSend;
            end
            StSend: begin
                busy            = 1'b1;
                ball.ball_valid = 1'b1;
                ball.ball_color = cur_color;
                ball.ball_last  = cur_last;
                if (ball.ball_ready && cur_last) state_d = StDone;
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            tray_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            blue_q    <= '0;
            red_q     <= '0;
            ovf_q     <= 1'b0;
            nb_prev_q <= 1'b0;
        end else begin
            // Edge detector runs in every state, so a rise while busy is dropped.
            nb_prev_q <= no_balls;
            state_q   <= state_d;
            case (state_q)
                StLoad: begin
                    snap_q <= tray_in;
                    n_q    <= n_clamped;
                    ovf_q  <= amount_ovf;
                    tray_q <= '0;
                    blue_q <= '0;
                    red_q  <= '0;
                    idx_q  <= '0;
                end
                StSend: begin
                    if (ball.ball_ready) begin
                        tray_q[idx_q] <= cur_color;
                        if (cur_color) red_q <= red_q + OneW;
                        else           blue_q <= blue_q + OneW;
                        idx_q <= idx_q + OneW;
                    end
                end
                default: ;
            endcase
        end
    end

    assign blue_count = blue_q;
    assign red_count  = red_q;
    assign tray_value = tray_q;
    assign overflow   = ovf_q;

endmodule
